// File: rtl/voq_request_gen.sv
// VOQ occupancy tracker and request generator feeding the crossbar scheduler.
// One counter per (input, output) pair; runs snapshot -> schedule -> sample -> dequeue rounds.
module voq_request_gen #(
  parameter int N            = 4,
  parameter int CW           = 4,
  parameter int SCHED_CYCLES = 5,
  parameter int PW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           arr_valid,
  input  logic [N-1:0][PW-1:0]   arr_dest,
  output logic [N-1:0]           arr_ready,
  output logic [N-1:0][N-1:0]    req_out,
  output logic                   sched_start,
  input  logic [N-1:0][N-1:0]    sched_decision,
  output logic [N-1:0]           deq_valid,
  output logic [N-1:0][PW-1:0]   deq_port,
  output logic                   busy,
  output logic                   err_grant
);

  localparam int             WW    = $clog2(SCHED_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX  = '1;
  localparam logic [CW-1:0]  C_ONE = CW'(1);
  localparam logic [WW-1:0]  WLOAD = WW'(SCHED_CYCLES - 1);
  localparam logic [WW-1:0]  W_ONE = WW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SAMPLE, S_APPLY} state_e;

  state_e                       state_q, state_d;
  logic [WW-1:0]                wcnt_q, wcnt_d;
  logic [N-1:0][N-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0][N-1:0]          nz, req_q, req_d, dec_q, dec_d;
  logic                         start_q, start_d, err_q, err_d;
  logic [N-1:0]                 deqv_q, deqv_d, acc, apply_v, bad_v, multi;
  logic [N-1:0][PW-1:0]         deqp_q, deqp_d, apply_p;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      assign arr_ready[gi] = (cnt_q[gi][arr_dest[gi]] != CMAX);
      for (gj = 0; gj < N; gj++) begin : g_col
        assign nz[gi][gj] = (cnt_q[gi][gj] != '0);
      end
    end
  endgenerate

  assign acc = arr_valid & arr_ready;

  // Lowest set bit of each latched decision row wins; an empty VOQ is flagged, not dequeued.
  always_comb begin
    apply_p = '0;
    apply_v = '0;
    bad_v   = '0;
    multi   = '0;
    for (int i = 0; i < N; i++) begin
      multi[i] = ($countones(sched_decision[i]) > 1);
      for (int j = N - 1; j >= 0; j--)
        if (dec_q[i][j]) apply_p[i] = PW'(j);
      if (state_q == S_APPLY && (|dec_q[i])) begin
        if (cnt_q[i][apply_p[i]] != '0) apply_v[i] = 1'b1;
        else                            bad_v[i]   = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (acc[i] && arr_dest[i] == PW'(j) && !(apply_v[i] && apply_p[i] == PW'(j)))
          cnt_d[i][j] = cnt_q[i][j] + C_ONE;
        else if (!(acc[i] && arr_dest[i] == PW'(j)) && apply_v[i] && apply_p[i] == PW'(j))
          cnt_d[i][j] = cnt_q[i][j] - C_ONE;
      end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    req_d   = req_q;
    dec_d   = dec_q;
    start_d = 1'b0;
    deqv_d  = '0;
    deqp_d  = '0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (|nz) begin
        req_d   = nz;
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        wcnt_d  = WLOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - W_ONE;
        if (wcnt_q == W_ONE) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        dec_d   = sched_decision;
        if (|multi) err_d = 1'b1;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        deqv_d = apply_v;
        for (int i = 0; i < N; i++)
          if (apply_v[i]) deqp_d[i] = apply_p[i];
        if (|bad_v) err_d = 1'b1;
        dec_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      dec_q   <= '0;
      start_q <= 1'b0;
      deqv_q  <= '0;
      deqp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dec_q   <= dec_d;
      start_q <= start_d;
      deqv_q  <= deqv_d;
      deqp_q  <= deqp_d;
      err_q   <= err_d;
    end
  end

  assign req_out     = req_q;
  assign sched_start = start_q;
  assign deq_valid   = deqv_q;
  assign deq_port    = deqp_q;
  assign busy        = (state_q != S_IDLE);
  assign err_grant   = err_q;

endmodule

// File: tb/tb_voq_request_gen.sv
// Randomized bench for voq_request_gen against a round-phase/occupancy reference model.
module tb_voq_request_gen;
  localparam int N = 4, CW = 4, SC = 5, PW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          arr_valid;
  logic [N-1:0][PW-1:0]  arr_dest;
  logic [N-1:0]          arr_ready;
  logic [N-1:0][N-1:0]   req_out;
  logic                  sched_start;
  logic [N-1:0][N-1:0]   sched_decision;
  logic [N-1:0]          deq_valid;
  logic [N-1:0][PW-1:0]  deq_port;
  logic                  busy, err_grant;

  always #5 clk = ~clk;

  voq_request_gen #(.N(N), .CW(CW), .SCHED_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .arr_valid(arr_valid), .arr_dest(arr_dest),
    .arr_ready(arr_ready), .req_out(req_out), .sched_start(sched_start),
    .sched_decision(sched_decision), .deq_valid(deq_valid), .deq_port(deq_port),
    .busy(busy), .err_grant(err_grant));

  int n_vec = 0, n_bad = 0;

  // Reference model: occupancy per VOQ plus the cycle position inside a round.
  // ph: 0 idle, 1 start pulse, 2..SC wait, SC+1 sample, SC+2 apply.
  int                    m_cnt[N][N];
  int                    ph;
  logic [N-1:0][N-1:0]   m_req, m_dec;
  logic [N-1:0]          m_dv;
  logic [N-1:0][PW-1:0]  m_dp;
  logic                  m_err;
  int                    dec_mode;   // 0 fixed, 1 legal random, 2 arbitrary random
  logic [N-1:0][N-1:0]   dec_fixed;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_cnt[i][j] = 0;
    ph = 0; m_req = '0; m_dec = '0; m_dv = '0; m_dp = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int nxt[N][N];
    int nph;
    logic any;
    logic [N-1:0] new_dv;
    logic [N-1:0][PW-1:0] new_dp;
    any = 1'b0; nph = 0; new_dv = '0; new_dp = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        nxt[i][j] = m_cnt[i][j];
        if (m_cnt[i][j] != 0) any = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (arr_valid[i] && m_cnt[i][arr_dest[i]] < CMAX) nxt[i][arr_dest[i]]++;
    if (ph == 0) begin
      if (any) begin
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m_req[i][j] = (m_cnt[i][j] != 0);
        nph = 1;
      end
    end else if (ph == SC + 1) begin
      m_dec = sched_decision;
      for (int i = 0; i < N; i++) if ($countones(sched_decision[i]) > 1) m_err = 1'b1;
      nph = SC + 2;
    end else if (ph == SC + 2) begin
      for (int i = 0; i < N; i++) begin
        int lo;
        lo = -1;
        for (int j = 0; j < N; j++) if (m_dec[i][j] && lo < 0) lo = j;
        if (lo >= 0) begin
          if (m_cnt[i][lo] == 0) m_err = 1'b1;
          else begin
            new_dv[i] = 1'b1;
            new_dp[i] = lo[PW-1:0];
            nxt[i][lo]--;
          end
        end
      end
      nph = 0;
    end else nph = ph + 1;
    m_cnt = nxt; m_dv = new_dv; m_dp = new_dp; ph = nph;
  endtask

  task automatic pick_dec();
    logic [N-1:0] row;
    int k;
    for (int i = 0; i < N; i++) begin
      row = '0;
      if (dec_mode == 0) row = dec_fixed[i];
      else if (dec_mode == 2) row = N'($urandom);
      else if (m_req[i] != '0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, N - 1);
        for (int t = 0; t < N; t++)
          if (row == '0 && m_req[i][(k + t) % N]) row[(k + t) % N] = 1'b1;
      end
      sched_decision[i] = row;
    end
  endtask

  task automatic check_outs();
    chk("sched_start", sched_start, ph == 1);
    chk("busy", busy, ph != 0);
    chk("deq_valid", deq_valid, m_dv);
    for (int i = 0; i < N; i++) if (m_dv[i]) chk("deq_port", deq_port[i], m_dp[i]);
    chk("req_out", req_out, m_req);
    chk("err_grant", err_grant, m_err);
  endtask

  // One clock: drive at negedge, check arr_ready, advance model at posedge, check at next negedge.
  task automatic tick(input logic [N-1:0] av, input logic [N-1:0][PW-1:0] ad);
    arr_valid = av; arr_dest = ad;
    if (ph == 1) pick_dec();
    #1;
    for (int i = 0; i < N; i++) chk("arr_ready", arr_ready[i], m_cnt[i][arr_dest[i]] != CMAX);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req_out", req_out, 0);
    chk("rst_sched_start", sched_start, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_port", deq_port, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_grant", err_grant, 0);
    model_clear();
    arr_valid = '0; arr_dest = '0; sched_decision = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0][PW-1:0] d;
    int n;
    bit done;
    reset = 1'b0; arr_valid = '0; arr_dest = '0; sched_decision = '0;
    dec_mode = 0; dec_fixed = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // single arrival 0->2, granted in the first round
    dec_fixed = '0; dec_fixed[0] = 4'b0100;
    d = '0; d[0] = 2'd2;
    tick(4'b0001, d);
    idle(12);

    // fill VOQ(1,3) to saturation, hold the 16th, then drain via grants
    do_reset();
    dec_fixed = '0;
    d = '0; d[1] = 2'd3;
    repeat (16) tick(4'b0010, d);
    chk("s2_full_ready", arr_ready[1], 1'b0);
    dec_fixed[1] = 4'b1000;
    repeat (20) tick(4'b0010, d);

    // VOQ(2,1) at 3 with an arrival landing in its APPLY cycle
    do_reset();
    dec_fixed = '0;
    d = '0; d[2] = 2'd1;
    repeat (3) tick(4'b0100, d);
    dec_fixed[2] = 4'b0010;
    done = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (ph == SC + 2 && !done) begin tick(4'b0100, d); done = 1'b1; end
      else idle(1);
    end

    // full permutation decision, every used VOQ at 1
    do_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = PW'((i + 1) % N);
      dec_fixed[i] = '0;
      dec_fixed[i][(i + 1) % N] = 1'b1;
    end
    tick(4'b1111, d);
    idle(20);

    // grant to empty VOQ(3,0)
    do_reset();
    dec_fixed = '0; dec_fixed[0] = 4'b0001; dec_fixed[3] = 4'b0001;
    d = '0;
    tick(4'b0001, d);
    idle(14);

    // reset in the middle of WAIT
    do_reset();
    dec_fixed = '0; dec_fixed[0] = 4'b0001;
    tick(4'b0001, '0);
    n = 0;
    while (ph != 3 && n < 20) begin idle(1); n++; end
    chk("s6_busy_before_reset", busy, 1'b1);
    do_reset();
    idle(15);

    // random traffic, legal decisions
    dec_mode = 1;
    for (int c = 0; c < 500; c++) tick(N'($urandom), (N * PW)'($urandom));

    // random traffic, arbitrary decisions
    do_reset();
    dec_mode = 2;
    for (int c = 0; c < 400; c++) tick(N'($urandom), (N * PW)'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/voq_request_gen.md
Name: voq_request_gen

Overview:
- Upstream neighbour of the crossbar scheduler.
- Keeps one cell-occupancy counter per virtual output queue (VOQ), i.e. per (input i, output j) pair.
- Presents a stable registered request matrix to the scheduler, pulses its start, and waits a fixed number of cycles for the scheduler's iterations.
- Samples the returned decision matrix, then decrements the granted VOQs and emits per-input dequeue commands to the input buffers.

Parameters:
- N, 4, number of input and output ports.
- CW, 4, VOQ counter width; a counter saturates at CMAX = 2^CW-1.
- SCHED_CYCLES, 5, cycles from the start pulse to a valid decision (IDLE handshake cycle plus four iterations).
- PW, $clog2(N), port-index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- arr_valid  in  [N-1:0]  cell arrival at input i.
- arr_dest  in  [N-1:0][PW-1:0]  destination output of the arrival at input i.
- arr_ready  out  [N-1:0]  VOQ (i, arr_dest[i]) not full; combinational.
- req_out  out  [N-1:0][N-1:0]  registered request snapshot; req_out[i][j] = VOQ(i,j) non-empty.
- sched_start  out  1  one-cycle start pulse to the scheduler.
- sched_decision  in  [N-1:0][N-1:0]  scheduler decision; row i has at most one bit set (output granted to input i).
- deq_valid  out  [N-1:0]  one-cycle dequeue command for input i.
- deq_port  out  [N-1:0][PW-1:0]  output port to dequeue toward; valid only with deq_valid[i].
- busy  out  1  high in every state except IDLE.
- err_grant  out  1  sticky: decision bit set for an empty VOQ, or row not one-hot/zero.

Behaviour:
- Reset (asynchronous, active-low): all counters 0, state IDLE; req_out 0, sched_start 0, deq_valid 0, deq_port 0, busy 0, err_grant 0.
- A reset asserted mid-round aborts the round immediately; no dequeue is issued.
- Arrival handshake:
  - A cell is accepted only when arr_valid[i] & arr_ready[i].
  - arr_ready[i] = (cnt[i][arr_dest[i]] != CMAX).
  - An arrival with arr_valid high and arr_ready low is not counted; the source must hold it.
- Counter update each cycle: cnt += accepted arrival; cnt -= dequeue applied this cycle.
  - A simultaneous arrival and dequeue on the same VOQ leaves the count unchanged.
  - The counter never wraps: a dequeue on 0 is ignored and sets err_grant; an increment at CMAX is impossible because of arr_ready.
- FSM states:
  - IDLE: if any cnt != 0, latch the snapshot req_out[i][j] = (cnt[i][j] != 0) and go to START. Otherwise stay.
  - START: sched_start = 1 for exactly this cycle; load the wait counter with SCHED_CYCLES-1; go to WAIT.
  - WAIT: decrement the wait counter; when it reaches 0, go to SAMPLE. req_out stays frozen during START, WAIT and SAMPLE.
  - SAMPLE: register sched_decision into dec_q; check legality; go to APPLY.
  - APPLY: for each row i with a bit at j, assert deq_valid[i] = 1 and deq_port[i] = j, and decrement cnt[i][j] this cycle. Return to IDLE.
- Round latency: start pulse to dequeue = SCHED_CYCLES + 2 cycles. Minimum spacing between start pulses = SCHED_CYCLES + 3 cycles.
- Dequeue checks:
  - A decision bit whose VOQ is 0 at APPLY sets err_grant and is not dequeued.
  - A row with more than one bit set sets err_grant; the lowest set index is used.
- Arrivals during a round are counted but do not appear in req_out until the next IDLE snapshot.
- deq_valid, deq_port and sched_start are registered outputs.
- err_grant clears only on reset.

Test Plan:
- Reset, then a single arrival at input 0 with arr_dest=2 -> at IDLE, req_out[0]=4'b0100; one sched_start pulse; decision row0=4'b0100 -> 7 cycles after start, deq_valid=4'b0001, deq_port[0]=2; cnt[0][2] back to 0.
- Fill VOQ(1,3) with 15 arrivals -> arr_ready[1]=0 while arr_dest[1]=3; a 16th held arrival is not counted; after one grant, arr_ready[1]=1 again.
- Arrival to VOQ(2,1) in the same cycle as its APPLY dequeue, with count=3 -> count stays 3; req_out[2][1] still 1 next round.
- Full permutation decision (row i grants output (i+1)%4), all VOQs at 1 -> all four deq_valid bits high in one cycle; all counts 0; FSM stays IDLE afterwards with no further start pulse.
- Decision grants VOQ(3,0) while its count is 0 -> err_grant=1 and sticky; no deq_valid[3]; count stays 0.
- Reset asserted during WAIT -> outputs 0 asynchronously, counters 0; after release, no start pulse until a new arrival.
